// File: rtl/avalon_dp_oc_ram.sv
// avalon_dp_oc_ram: true-dual-port on-chip RAM with two Avalon-MM slave ports,
// pipelined reads, write-collision stall on s2, SLVERR on out-of-range and clock-enable freeze.
module avalon_dp_oc_ram #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 13,
  parameter int    DEPTH     = 5120,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = "oc_ram.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [1:0]          s1_response,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic [1:0]          s2_response,
  output logic                s2_waitrequest
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  // Contents are preloaded by the device programming flow from INIT_FILE.
  logic unused_init;
  assign unused_init = (INIT_FILE != "");
  logic s1_inr, s2_inr, s1_wr, s2_wr, s1_rd, s2_rd, collision;
  logic coll_q, coll_d;
  logic s1_v1_q, s1_v1_d, s1_e1_q, s1_e1_d, s1_v2_q, s1_v2_d, s1_e2_q, s1_e2_d;
  logic s2_v1_q, s2_v1_d, s2_e1_q, s2_e1_d, s2_v2_q, s2_v2_d, s2_e2_q, s2_e2_d;
  logic [DATA_W-1:0] s1_d1_q, s1_d1_d, s1_d2_q, s1_d2_d;
  logic [DATA_W-1:0] s2_d1_q, s2_d1_d, s2_d2_q, s2_d2_d;
  always_comb begin
    s1_inr = {1'b0, s1_address} < LIMIT;
    s2_inr = {1'b0, s2_address} < LIMIT;
    // coll_q blocks a second stall of the request held after a collision
    collision = reset_n & clken & ~coll_q & s1_chipselect & s1_write & s2_chipselect & s2_write
              & s1_inr & (s1_address == s2_address);
    s2_waitrequest = reset_n & (~clken | collision);
    s1_wr = reset_n & clken & s1_chipselect & s1_write;
    s1_rd = reset_n & clken & s1_chipselect & s1_read & ~s1_write;
    s2_wr = reset_n & clken & ~collision & s2_chipselect & s2_write;
    s2_rd = reset_n & clken & ~collision & s2_chipselect & s2_read & ~s2_write;
    coll_d = clken ? collision : coll_q;
    s1_v1_d = clken ? s1_rd : s1_v1_q;
    s1_e1_d = s1_rd ? ~s1_inr : s1_e1_q;
    s1_d1_d = s1_rd ? (s1_inr ? mem[s1_address[IW-1:0]] : '0) : s1_d1_q;
    s1_v2_d = clken ? s1_v1_q : s1_v2_q;
    s1_e2_d = (clken & s1_v1_q) ? s1_e1_q : s1_e2_q;
    s1_d2_d = (clken & s1_v1_q) ? s1_d1_q : s1_d2_q;
    s2_v1_d = clken ? s2_rd : s2_v1_q;
    s2_e1_d = s2_rd ? ~s2_inr : s2_e1_q;
    s2_d1_d = s2_rd ? (s2_inr ? mem[s2_address[IW-1:0]] : '0) : s2_d1_q;
    s2_v2_d = clken ? s2_v1_q : s2_v2_q;
    s2_e2_d = (clken & s2_v1_q) ? s2_e1_q : s2_e2_q;
    s2_d2_d = (clken & s2_v1_q) ? s2_d1_q : s2_d2_q;
  end
  always_comb begin
    s1_readdatavalid = reset_n & clken & (RD_LAT == 2 ? s1_v2_q : s1_v1_q);
    s2_readdatavalid = reset_n & clken & (RD_LAT == 2 ? s2_v2_q : s2_v1_q);
    s1_readdata = s1_readdatavalid ? (RD_LAT == 2 ? s1_d2_q : s1_d1_q) : '0;
    s2_readdata = s2_readdatavalid ? (RD_LAT == 2 ? s2_d2_q : s2_d1_q) : '0;
    s1_response = (s1_readdatavalid & (RD_LAT == 2 ? s1_e2_q : s1_e1_q)) ? 2'b10 : 2'b00;
    s2_response = (s2_readdatavalid & (RD_LAT == 2 ? s2_e2_q : s2_e1_q)) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      coll_q  <= 1'b0;
      s1_v1_q <= 1'b0;
      s1_e1_q <= 1'b0;
      s1_d1_q <= '0;
      s1_v2_q <= 1'b0;
      s1_e2_q <= 1'b0;
      s1_d2_q <= '0;
      s2_v1_q <= 1'b0;
      s2_e1_q <= 1'b0;
      s2_d1_q <= '0;
      s2_v2_q <= 1'b0;
      s2_e2_q <= 1'b0;
      s2_d2_q <= '0;
    end else begin
      coll_q  <= coll_d;
      s1_v1_q <= s1_v1_d;
      s1_e1_q <= s1_e1_d;
      s1_d1_q <= s1_d1_d;
      s1_v2_q <= s1_v2_d;
      s1_e2_q <= s1_e2_d;
      s1_d2_q <= s1_d2_d;
      s2_v1_q <= s2_v1_d;
      s2_e1_q <= s2_e1_d;
      s2_d1_q <= s2_d1_d;
      s2_v2_q <= s2_v2_d;
      s2_e2_q <= s2_e2_d;
      s2_d2_q <= s2_d2_d;
    end
  end
  // s2 is written last so its lanes win when both ports hit one word
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (s1_wr && s1_inr && s1_byteenable[i]) mem[s1_address[IW-1:0]][8*i +: 8] <= s1_writedata[8*i +: 8];
      if (s2_wr && s2_inr && s2_byteenable[i]) mem[s2_address[IW-1:0]][8*i +: 8] <= s2_writedata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_avalon_dp_oc_ram.sv
// tb_avalon_dp_oc_ram: drives a latency-1 and a latency-2 RAM with identical stimulus
// and checks both against a memory-array model with age-tagged pending reads.
module tb_avalon_dp_oc_ram;
  localparam int DEPTH = 5120;
  typedef struct { int age; logic [31:0] data; logic err; } ent_t;
  logic clk = 1'b0;
  logic reset_n, clken;
  logic cs [2], rd [2], wr [2];
  logic [12:0] addr [2];
  logic [3:0] be [2];
  logic [31:0] wd [2];
  logic [31:0] rdata [2][2];
  logic rvalid [2][2];
  logic [1:0] resp [2][2];
  logic wreq [2];
  logic [31:0] mem_m [DEPTH];
  ent_t pq [2][$];
  logic stalled, w_exp;
  int checks = 0, errors = 0;
  logic [31:0] v1, v2;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalon_dp_oc_ram #(.DATA_W(32), .ADDR_W(13), .DEPTH(DEPTH), .RD_LAT(g + 1), .INIT_FILE("")) u_dut (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]), .s1_address(addr[0]),
      .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[g][0]),
      .s1_readdatavalid(rvalid[g][0]), .s1_response(resp[g][0]),
      .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]), .s2_address(addr[1]),
      .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[g][1]),
      .s2_readdatavalid(rvalid[g][1]), .s2_response(resp[g][1]),
      .s2_waitrequest(wreq[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
  endtask
  task automatic req(input int p, input logic r, input logic w, input int a, input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; rd[p] = r; wr[p] = w; addr[p] = 13'(a); be[p] = b; wd[p] = d;
  endtask
  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic cyc();
    logic [31:0] ed;
    logic ev, ee;
    logic acc [2];
    @(negedge clk);
    w_exp = reset_n && (!clken || (cs[0] && wr[0] && cs[1] && wr[1] && addr[0] == addr[1]
            && int'(addr[0]) < DEPTH && !stalled));
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat%0d_waitrequest", d + 1), {31'd0, wreq[d]}, {31'd0, w_exp});
      for (int p = 0; p < 2; p++) begin
        ev = 1'b0; ed = '0; ee = 1'b0;
        for (int k = 0; k < pq[p].size(); k++)
          if (pq[p][k].age == d + 1 && reset_n && clken) begin
            ev = 1'b1; ed = pq[p][k].data; ee = pq[p][k].err;
          end
        chk($sformatf("lat%0d_s%0d_valid", d + 1, p + 1), {31'd0, rvalid[d][p]}, {31'd0, ev});
        if (ev) begin
          chk($sformatf("lat%0d_s%0d_data", d + 1, p + 1), rdata[d][p], ed);
          chk($sformatf("lat%0d_s%0d_resp", d + 1, p + 1), {30'd0, resp[d][p]}, ee ? 32'd2 : 32'd0);
        end
      end
    end
    @(posedge clk);
    if (!reset_n) begin
      pq[0].delete(); pq[1].delete(); stalled = 1'b0;
    end else if (clken) begin
      acc[0] = cs[0] && (rd[0] || wr[0]);
      acc[1] = cs[1] && (rd[1] || wr[1]) && !w_exp;
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < pq[p].size(); k++) pq[p][k].age = pq[p][k].age + 1;
        while (pq[p].size() > 0 && pq[p][0].age > 2) void'(pq[p].pop_front());
        if (acc[p] && rd[p] && !wr[p])
          pq[p].push_back('{1, int'(addr[p]) < DEPTH ? mem_m[addr[p]] : 32'd0, int'(addr[p]) >= DEPTH});
      end
      for (int p = 0; p < 2; p++)
        if (acc[p] && wr[p] && int'(addr[p]) < DEPTH)
          for (int b = 0; b < 4; b++) if (be[p][b]) mem_m[addr[p]][8*b +: 8] = wd[p][8*b +: 8];
      stalled = w_exp;
    end
    #1;
  endtask
  function automatic int pick_addr();
    int r;
    r = $urandom_range(0, 15);
    return r < 12 ? 100 + $urandom_range(0, 3) : r == 12 ? 5119 : r == 13 ? 5120 : r == 14 ? 8191
         : $urandom_range(0, DEPTH - 1);
  endfunction
  task automatic rnd_port(input int p);
    cs[p] = $urandom_range(0, 7) != 0; rd[p] = 1'($urandom); wr[p] = 1'($urandom);
    addr[p] = 13'(pick_addr()); be[p] = 4'($urandom); wd[p] = $urandom;
  endtask
  initial begin
    stalled = 1'b0; w_exp = 1'b0; reset_n = 1'b0; clken = 1'b1; idle();
    cyc(); cyc();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        chk("reset_readdata", rdata[d][p], 32'd0);
        chk("reset_response", {30'd0, resp[d][p]}, 32'd0);
      end
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) begin
      req(0, 1'b0, 1'b1, i, 4'hF, $urandom);
      req(1, 1'b0, 1'b1, i + DEPTH / 2, 4'hF, $urandom);
      cyc();
    end
    idle(); req(0, 1'b0, 1'b1, 0, 4'hF, 32'hDEADBEEF); cyc();
    idle(); req(0, 1'b1, 1'b0, 0, 4'h0, 32'd0); cyc();
    chk("word0_lat1", rdata[0][0], 32'hDEADBEEF);
    chk("word0_lat1_resp", {30'd0, resp[0][0]}, 32'd0);
    idle(); cyc();
    chk("word0_lat2", rdata[1][0], 32'hDEADBEEF);
    chk("word0_lat1_pulse", {31'd0, rvalid[0][0]}, 32'd0);
    req(0, 1'b0, 1'b1, 10, 4'hF, 32'h11223344); cyc();
    req(0, 1'b0, 1'b1, 10, 4'h5, 32'hAABBCCDD); cyc();
    idle(); req(1, 1'b1, 1'b0, 10, 4'h0, 32'd0); cyc();
    chk("bytelane_lat1", rdata[0][1], 32'h11BB33DD);
    idle(); cyc();
    chk("bytelane_lat2", rdata[1][1], 32'h11BB33DD);
    req(0, 1'b0, 1'b1, 100, 4'hF, 32'h000000AA);
    req(1, 1'b0, 1'b1, 100, 4'hF, 32'h000000BB);
    #1 chk("collision_stall", {31'd0, wreq[0]}, 32'd1);
    cyc();
    cs[0] = 1'b0; wr[0] = 1'b0;
    #1 chk("collision_release", {31'd0, wreq[1]}, 32'd0);
    cyc();
    idle(); req(0, 1'b1, 1'b0, 100, 4'h0, 32'd0); cyc();
    chk("collision_final", rdata[0][0], 32'h000000BB);
    idle(); req(0, 1'b0, 1'b1, 7, 4'hF, 32'h12); cyc();
    req(0, 1'b0, 1'b1, 7, 4'hF, 32'h55); req(1, 1'b1, 1'b0, 7, 4'h0, 32'd0); cyc();
    chk("rdw_old", rdata[0][1], 32'h12);
    idle(); req(1, 1'b1, 1'b0, 7, 4'h0, 32'd0); cyc();
    chk("rdw_new_lat1", rdata[0][1], 32'h55);
    chk("rdw_old_lat2", rdata[1][1], 32'h12);
    idle(); cyc();
    v1 = mem_m[1]; v2 = mem_m[2];
    req(0, 1'b1, 1'b0, 1, 4'h0, 32'd0); cyc();
    chk("pipe_lat2_early", {31'd0, rvalid[1][0]}, 32'd0);
    req(0, 1'b1, 1'b0, 5120, 4'h0, 32'd0); cyc();
    chk("pipe_a_valid", {31'd0, rvalid[1][0]}, 32'd1);
    chk("pipe_a_data", rdata[1][0], v1);
    req(0, 1'b1, 1'b0, 2, 4'h0, 32'd0); cyc();
    chk("pipe_b_valid", {31'd0, rvalid[1][0]}, 32'd1);
    chk("pipe_b_resp", {30'd0, resp[1][0]}, 32'd2);
    chk("pipe_b_data", rdata[1][0], 32'd0);
    req(0, 1'b0, 1'b1, 5200, 4'hF, 32'hCAFEF00D); cyc();
    chk("pipe_c_valid", {31'd0, rvalid[1][0]}, 32'd1);
    chk("pipe_c_resp", {30'd0, resp[1][0]}, 32'd0);
    chk("pipe_c_data", rdata[1][0], v2);
    idle(); cyc();
    chk("pipe_end", {31'd0, rvalid[1][0]}, 32'd0);
    v1 = mem_m[80];
    req(0, 1'b1, 1'b0, 80, 4'h0, 32'd0); cyc();
    chk("oob_write_alias", rdata[0][0], v1);
    idle(); req(0, 1'b1, 1'b0, 3, 4'h0, 32'd0); cyc();
    idle(); clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hold", {31'd0, rvalid[0][0]}, 32'd0);
      cyc();
    end
    clken = 1'b1;
    #1 chk("stall_release", {31'd0, rvalid[0][0]}, 32'd1);
    cyc();
    chk("stall_release_lat2", {31'd0, rvalid[1][0]}, 32'd1);
    cyc();
    req(0, 1'b1, 1'b0, 4, 4'h0, 32'd0); cyc();
    idle(); reset_n = 1'b0;
    #1 chk("reset_drop_lat1", {31'd0, rvalid[0][0]}, 32'd0);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_drop_lat2", {31'd0, rvalid[1][0]}, 32'd0);
      cyc();
    end
    for (int n = 0; n < 3000; n++) begin
      clken = $urandom_range(0, 9) != 0;
      rnd_port(0);
      if (!w_exp) rnd_port(1);
      cyc();
    end
    idle(); clken = 1'b1; cyc(); cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avalon_dp_oc_ram.md
Name: avalon_dp_oc_ram

Overview:
- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 and s2, on one clock.
- Intended use: s1 serves the CPU data/instruction master; s2 serves a DMA or second CPU, giving shared-memory inter-processor communication in the MSOC.
- Adds the following: configurable width/depth, pipelined reads with readdatavalid, write-collision arbitration, out-of-range error response, and clock-enable stall.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 13, word-address width.
- DEPTH, 5120, number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 (2 adds an output register).
- INIT_FILE, "oc_ram.hex", memory initialisation file; an empty string means no initialisation.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- clken  in  1  global clock enable; when low, all state is frozen.
- s1_chipselect, s2_chipselect  in  1  port select.
- s1_read, s2_read  in  1  read request.
- s1_write, s2_write  in  1  write request.
- s1_address, s2_address  in  ADDR_W  word address.
- s1_byteenable, s2_byteenable  in  DATA_W/8  byte lanes.
- s1_writedata, s2_writedata  in  DATA_W  write data.
- s1_readdata, s2_readdata  out  DATA_W  read data.
- s1_readdatavalid, s2_readdatavalid  out  1  read data strobe.
- s1_response, s2_response  out  2  2'b00 = OKAY, 2'b10 = SLVERR; valid with readdatavalid.
- s2_waitrequest  out  1  s2 stall; s1 never stalls.

Behaviour:
- Reset: one clock with reset_n low clears all outputs, pipelines and the collision flag. readdata=0, readdatavalid=0, response=0, s2_waitrequest=0. RAM contents are not cleared.
- Accepted request: chipselect & (read|write) & ~waitrequest & clken. read and write asserted together on one port is illegal; write takes priority and the read is dropped.
- Write: each lane i with byteenable[i]=1 is updated at the clock edge. byteenable=0 is a legal no-op write.
- Read: readdata/readdatavalid/response are presented exactly RD_LAT cycles after acceptance, as a one-cycle valid pulse. Back-to-back reads are fully pipelined, one per cycle per port.
- Out of range (address >= DEPTH):
  - The write is discarded.
  - A read returns readdata=0 and response=2'b10 at normal latency.
- Read-during-write on the same address, either port or cross-port, returns the OLD data.
- Write collision (s1 and s2 both write the same in-range address in the same cycle):
  - The s1 write is performed; s2_waitrequest=1 combinationally that cycle.
  - The s2 master must hold its request. It is accepted the next cycle, so s2 data is the final content, overlaid on whichever of its byte lanes were enabled.
  - s2_waitrequest never stays high 2 consecutive cycles for the same held request; a collision flag register blocks re-stall.
- Any other s1/s2 overlap (different addresses, read/write on the same address, read/read) causes no stall.
- clken=0:
  - No access is accepted and no write is performed.
  - The read pipeline holds, and any pending readdatavalid pulse is delayed until clken returns.
  - s2_waitrequest is forced to 1.
- Reset mid-read: pending reads are discarded and no readdatavalid is issued for them.
- Address arithmetic: no wrap; comparisons are unsigned at ADDR_W bits.

Test Plan:
- Reset then read: reset_n low 2 cycles, then s1 reads addr 0 with INIT_FILE word 0 = 0xDEADBEEF, RD_LAT=1 -> one cycle later s1_readdata=0xDEADBEEF, readdatavalid=1 for 1 cycle, response=00. All outputs are 0 during reset.
- Byte-lane write: s1 writes 0x11223344 to addr 10 with byteenable=4'b1111, then 0xAABBCCDD with byteenable=4'b0101. s2 then reads addr 10 -> 0x11BB33DD.
- Collision: same cycle, s1 writes 0x000000AA and s2 writes 0x000000BB to addr 100, all lanes enabled -> s2_waitrequest=1 for exactly 1 cycle, s2 accepted next cycle, later read of addr 100 = 0x000000BB.
- Read-during-write: s1 writes 0x55 to addr 7, which holds 0x12, while s2 reads addr 7 -> s2_readdata=0x12; a read the next cycle returns 0x55.
- Pipeline plus error at RD_LAT=2, DEPTH=5120: s1 issues back-to-back reads to addr 1, 5120, 2 -> valid pulses on 3 consecutive cycles starting 2 cycles after the first read. Responses are 00, 10, 00; the middle readdata=0. A write to 5200 leaves memory unchanged.
- clken stall/reset: s1 read accepted, clken=0 for 3 cycles -> readdatavalid is held off until clken=1, then issued. In a separate run, reset_n asserted the cycle after a read -> no readdatavalid is ever issued.
